// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, default widths and bank mapping for the banked warp regfile
package regfile_pkg;
    localparam int DEF_THREADS_PER_WARP = 32;
    localparam int DEF_NUM_WARPS        = 64;
    localparam int DEF_NUM_REGS         = 32;
    localparam int DEF_DATA_WIDTH       = 32;
    localparam int DEF_NUM_BANKS        = 4;
    localparam int CNT_W                = 16;

    typedef enum logic [0:0] {IDLE = 1'b0, SECOND = 1'b1} rf_state_e;

    // Warp swizzle: the same register of neighbouring warps lands in different banks.
    function automatic int bank_of(input int warp, input int rg,
                                   input int num_banks = DEF_NUM_BANKS);
        return (warp + rg) % num_banks;
    endfunction

    function automatic int entry_of(input int warp, input int rg,
                                    input int num_regs = DEF_NUM_REGS,
                                    input int num_banks = DEF_NUM_BANKS);
        return warp * (num_regs / num_banks) + rg / num_banks;
    endfunction
endpackage

// File: rtl/warp_regfile_banked_bank.sv
// rtl/warp_regfile_banked_bank.sv - one 1R1W register bank, synchronous read, per-lane write enable
module regfile_bank #(
    parameter int DEPTH      = 512,
    parameter int LANES      = 32,
    parameter int DATA_WIDTH = 32,
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int ROW_W     = LANES * DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ROW_W-1:0]  rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LANES-1:0]  wr_mask,
    input  logic [ROW_W-1:0]  wr_data
);
    logic [ROW_W-1:0] mem [DEPTH];

    // Read returns the pre-write contents; the top level supplies same-cycle bypass.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_mask[l]) mem[wr_addr][l*DATA_WIDTH +: DATA_WIDTH] <= wr_data[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/warp_regfile_banked.sv
// rtl/warp_regfile_banked.sv - banked per-warp vector regfile with conflict serialisation and write bypass
module warp_regfile_banked
    import regfile_pkg::*;
#(
    parameter int THREADS_PER_WARP = DEF_THREADS_PER_WARP,
    parameter int NUM_WARPS        = DEF_NUM_WARPS,
    parameter int NUM_REGS         = DEF_NUM_REGS,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int NUM_BANKS        = DEF_NUM_BANKS,
    localparam int WARP_W          = $clog2(NUM_WARPS),
    localparam int REG_W           = $clog2(NUM_REGS),
    localparam int LANES_W         = THREADS_PER_WARP * DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rd_req_valid,
    output logic                        rd_req_ready,
    input  logic [WARP_W-1:0]           rd_warp_id,
    input  logic [REG_W-1:0]            rs1_addr,
    input  logic [REG_W-1:0]            rs2_addr,
    output logic                        rd_rsp_valid,
    output logic [LANES_W-1:0]          rs1_data,
    output logic [LANES_W-1:0]          rs2_data,
    input  logic                        wr_en,
    input  logic [WARP_W-1:0]           wr_warp_id,
    input  logic [REG_W-1:0]            wr_addr,
    input  logic [THREADS_PER_WARP-1:0] wr_mask,
    input  logic [LANES_W-1:0]          wr_data,
    output logic [CNT_W-1:0]            conflict_count
);
    localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int DEPTH   = NUM_WARPS * NUM_REGS / NUM_BANKS;
    localparam int ENTRY_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_SECOND = SECOND;

    logic [0:0]          state;
    logic [WARP_W-1:0]   warp2_q, r2_warp;
    logic [REG_W-1:0]    rs2_q, r2_reg;
    logic                accept, conflict, rd2_act, wr_live, byp1, byp2;
    logic [BANK_W-1:0]   b1, b2, wb, s1_bank, s2_bank;
    logic [ENTRY_W-1:0]  e1, e2, we;
    logic                rsp_q, cap_q, hold_q, s1_zero, s2_zero;
    logic [THREADS_PER_WARP-1:0] s1_mask, s2_mask;
    logic [LANES_W-1:0]  byp_data, rs1_hold, rs1_last, rs2_last, op1_fresh, op2_fresh;
    logic [LANES_W-1:0]  bank_rd_data [NUM_BANKS];

    assign rd_req_ready = (state == ST_IDLE) && rst_n;
    assign accept       = rd_req_valid && rd_req_ready;
    assign r2_warp      = (state == ST_SECOND) ? warp2_q : rd_warp_id;
    assign r2_reg       = (state == ST_SECOND) ? rs2_q : rs2_addr;

    assign b1 = BANK_W'(bank_of(int'(rd_warp_id), int'(rs1_addr), NUM_BANKS));
    assign b2 = BANK_W'(bank_of(int'(r2_warp), int'(r2_reg), NUM_BANKS));
    assign wb = BANK_W'(bank_of(int'(wr_warp_id), int'(wr_addr), NUM_BANKS));
    assign e1 = ENTRY_W'(entry_of(int'(rd_warp_id), int'(rs1_addr), NUM_REGS, NUM_BANKS));
    assign e2 = ENTRY_W'(entry_of(int'(r2_warp), int'(r2_reg), NUM_REGS, NUM_BANKS));
    assign we = ENTRY_W'(entry_of(int'(wr_warp_id), int'(wr_addr), NUM_REGS, NUM_BANKS));

    // rs1==rs2 shares a single bank read, so only distinct registers conflict.
    assign conflict = (b1 == b2) && (rs1_addr != rs2_addr);
    assign rd2_act  = (accept && !conflict) || (state == ST_SECOND);
    assign wr_live  = wr_en && (wr_addr != '0);
    assign byp1     = wr_live && (wr_warp_id == rd_warp_id) && (wr_addr == rs1_addr);
    assign byp2     = wr_live && (wr_warp_id == r2_warp) && (wr_addr == r2_reg);

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic hit1, hit2;
        assign hit1 = accept && (b1 == BANK_W'(k));
        assign hit2 = rd2_act && (b2 == BANK_W'(k));
        regfile_bank #(
            .DEPTH(DEPTH), .LANES(THREADS_PER_WARP), .DATA_WIDTH(DATA_WIDTH)
        ) u_bank (
            .clk     (clk),
            .rd_en   (hit1 || hit2),
            .rd_addr (hit2 ? e2 : e1),
            .rd_data (bank_rd_data[k]),
            .wr_en   (wr_live && (wb == BANK_W'(k))),
            .wr_addr (we),
            .wr_mask (wr_mask),
            .wr_data (wr_data)
        );
    end

    always_ff @(posedge clk) begin
        s1_bank  <= b1;
        s2_bank  <= b2;
        s1_zero  <= (rs1_addr == '0);
        s2_zero  <= (r2_reg == '0);
        s1_mask  <= byp1 ? wr_mask : '0;
        s2_mask  <= byp2 ? wr_mask : '0;
        byp_data <= wr_data;
        if (cap_q) rs1_hold <= op1_fresh;
    end

    always_comb begin
        op1_fresh = bank_rd_data[s1_bank];
        op2_fresh = bank_rd_data[s2_bank];
        for (int l = 0; l < THREADS_PER_WARP; l++) begin
            if (s1_mask[l]) op1_fresh[l*DATA_WIDTH +: DATA_WIDTH] = byp_data[l*DATA_WIDTH +: DATA_WIDTH];
            if (s2_mask[l]) op2_fresh[l*DATA_WIDTH +: DATA_WIDTH] = byp_data[l*DATA_WIDTH +: DATA_WIDTH];
        end
        if (s1_zero) op1_fresh = '0;
        if (s2_zero) op2_fresh = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            warp2_q        <= '0;
            rs2_q          <= '0;
            rsp_q          <= 1'b0;
            cap_q          <= 1'b0;
            hold_q         <= 1'b0;
            conflict_count <= '0;
            rs1_last       <= '0;
            rs2_last       <= '0;
        end else begin
            rsp_q  <= 1'b0;
            cap_q  <= 1'b0;
            hold_q <= 1'b0;
            if (rsp_q) begin
                rs1_last <= rs1_data;
                rs2_last <= rs2_data;
            end
            case (state)
                ST_IDLE: begin
                    if (accept && conflict) begin
                        state   <= ST_SECOND;
                        warp2_q <= rd_warp_id;
                        rs2_q   <= rs2_addr;
                        cap_q   <= 1'b1;
                    end else if (accept) begin
                        rsp_q <= 1'b1;
                    end
                end
                ST_SECOND: begin
                    state  <= ST_IDLE;
                    rsp_q  <= 1'b1;
                    hold_q <= 1'b1;
                    if (conflict_count != {CNT_W{1'b1}}) conflict_count <= conflict_count + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rd_rsp_valid = rsp_q;
    assign rs1_data     = rsp_q ? (hold_q ? rs1_hold : op1_fresh) : rs1_last;
    assign rs2_data     = rsp_q ? op2_fresh : rs2_last;
endmodule

// File: tb/tb_warp_regfile_banked.sv
// tb/tb_warp_regfile_banked.sv - directed scoreboard bench for warp_regfile_banked
module tb_warp_regfile_banked;
    localparam int T  = 32;
    localparam int W  = 64;
    localparam int R  = 32;
    localparam int DW = 32;
    localparam int LW = T * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic [5:0]    rd_warp_id = '0;
    logic [4:0]    rs1_addr = '0, rs2_addr = '0;
    logic          rd_rsp_valid;
    logic [LW-1:0] rs1_data, rs2_data;
    logic          wr_en = 1'b0;
    logic [5:0]    wr_warp_id = '0;
    logic [4:0]    wr_addr = '0;
    logic [T-1:0]  wr_mask = '0;
    logic [LW-1:0] wr_data = '0;
    logic [15:0]   conflict_count;

    warp_regfile_banked dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_warp_id(rd_warp_id), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_rsp_valid(rd_rsp_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wr_en(wr_en), .wr_warp_id(wr_warp_id), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data), .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [LW-1:0] e1;
        logic [LW-1:0] e2;
        int            due;
    } exp_t;

    exp_t          sb[$];
    exp_t          got;
    logic [LW-1:0] model [W][R];
    int            vectors = 0;
    int            miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        int bad;
        bad = -1;
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            for (int l = T - 1; l >= 0; l--)
                if (obs[l*DW +: DW] !== expv[l*DW +: DW]) bad = l;
            $error("FAIL %s lane %0d observed=%h expected=%h", tag, bad,
                   obs[bad*DW +: DW], expv[bad*DW +: DW]);
        end
    endtask

    function automatic logic [LW-1:0] pat(input logic [31:0] base);
        logic [LW-1:0] v;
        for (int i = 0; i < T; i++) v[i*DW +: DW] = base + 32'(i);
        return v;
    endfunction

    function automatic logic [LW-1:0] model_read(input int w, input int r);
        return (r == 0) ? '0 : model[w][r];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req_valid = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic set_write(input int w, input int r, input logic [T-1:0] m, input logic [LW-1:0] d);
        wr_en = 1'b1;
        wr_warp_id = 6'(w);
        wr_addr = 5'(r);
        wr_mask = m;
        wr_data = d;
        if (r != 0)
            for (int l = 0; l < T; l++)
                if (m[l]) model[w][r][l*DW +: DW] = d[l*DW +: DW];
    endtask

    task automatic wr(input int w, input int r, input logic [LW-1:0] d);
        set_write(w, r, '1, d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drive_rd(input int w, input int r1, input int r2);
        chk("req_ready", rd_req_ready, 1);
        rd_req_valid = 1'b1;
        rd_warp_id = 6'(w);
        rs1_addr = 5'(r1);
        rs2_addr = 5'(r2);
    endtask

    // Any same-cycle write must be set before this so the model already holds it.
    task automatic issue(input int w, input int r1, input int r2, input int lat);
        exp_t e;
        drive_rd(w, r1, r2);
        e.e1 = model_read(w, r1);
        e.e2 = model_read(w, r2);
        e.due = cyc + lat;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rd_rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", rd_rsp_valid, 0);
            end else begin
                got = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(got.due));
                chk_wide("rs1_data", rs1_data, got.e1);
                chk_wide("rs2_data", rs2_data, got.e2);
            end
        end
    end

    initial begin
        exp_t e;
        tick();
        chk("reset_ready", rd_req_ready, 0);
        chk("reset_rsp_valid", rd_rsp_valid, 0);
        chk("reset_rs1_data", rs1_data[63:0], 0);
        chk("reset_rs2_data", rs2_data[63:0], 0);
        chk("reset_count", conflict_count, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", rd_req_ready, 1);
        tick();

        wr(3, 5, pat(32'h0));
        wr(3, 6, pat(32'h100));
        issue(3, 5, 6, 1);
        tick(); idle(); tick();
        chk_wide("hold_rs1", rs1_data, pat(32'h0));

        wr(0, 1, pat(32'h200));
        wr(0, 5, pat(32'h300));
        issue(0, 1, 5, 2);
        tick(); idle();
        chk("conflict_ready_n1", rd_req_ready, 0);
        chk("count_before_second", conflict_count, 0);
        tick();
        chk("conflict_ready_n2", rd_req_ready, 1);
        chk("count_after_conflict", conflict_count, 1);
        tick();

        wr(0, 2, pat(32'h400));
        wr(0, 6, pat(32'h500));
        issue(0, 1, 2, 1); tick();
        issue(0, 5, 6, 1); tick();
        issue(0, 2, 1, 1); tick();
        issue(0, 1, 1, 1); tick();
        idle(); tick(); tick();
        chk("count_b2b", conflict_count, 1);

        set_write(0, 0, '1, {T{32'hDEADBEEF}});
        issue(0, 0, 0, 1);
        tick(); idle();
        issue(0, 0, 0, 1);
        tick(); idle(); tick(); tick();
        chk("count_reg0", conflict_count, 1);

        wr(2, 7, pat(32'h600));
        wr(2, 8, pat(32'h700));
        set_write(2, 7, 32'h0000FFFF, {T{32'hA5A5A5A5}});
        issue(2, 7, 8, 1);
        tick(); idle(); tick();
        issue(2, 7, 7, 1);
        tick(); idle(); tick(); tick();

        wr(1, 3, pat(32'h800));
        wr(1, 7, pat(32'h900));
        drive_rd(1, 3, 7);
        e.e1 = model_read(1, 3);
        e.due = cyc + 2;
        tick(); idle();
        chk("second_ready", rd_req_ready, 0);
        set_write(1, 7, 32'hFFFF0000, {T{32'h12345678}});
        e.e2 = model_read(1, 7);
        sb.push_back(e);
        tick(); idle(); tick();
        chk("count_second_bypass", conflict_count, 2);

        force dut.conflict_count = 16'hFFFD;
        #1;
        release dut.conflict_count;
        for (int i = 0; i < 3; i++) begin
            issue(0, 1, 5, 2);
            tick(); idle(); tick();
            chk("count_saturate", conflict_count, (i == 0) ? 16'hFFFE : 16'hFFFF);
            tick();
        end

        wr(4, 2, pat(32'hA00));
        wr(4, 6, pat(32'hB00));
        drive_rd(4, 2, 6);
        tick(); idle();
        chk("pre_reset_ready", rd_req_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_ready", rd_req_ready, 0);
        chk("mid_reset_count", conflict_count, 0);
        chk("mid_reset_rsp_valid", rd_rsp_valid, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", rd_req_ready, 1);
        tick();
        chk("post_reset_no_rsp", rd_rsp_valid, 0);
        issue(4, 2, 2, 1);
        tick(); idle(); tick(); tick();

        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        chk("scoreboard_drained", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/warp_regfile_banked.md
# warp_regfile_banked

Banked, per-warp vector register file serving the execution stage. It is the parametrised successor to the flat single-warp regfile port set, generalised in warp count, register count, lane count, data width and bank count. Each bank has one read port and one write port, and same-bank read pairs are detected and serialised. The read request/response is a valid/ready handshake, and writes are lane-masked with same-cycle write-to-read bypass. It sits between the execution stage (operand fetch and writeback) and nothing downstream; the scheduler sees it only through `rd_req_ready` backpressure.

## Interface
- `THREADS_PER_WARP`, 32, lanes per warp.
- `NUM_WARPS`, 64, resident warps.
- `NUM_REGS`, 32, architectural registers per warp.
- `DATA_WIDTH`, 32, bits per lane.
- `NUM_BANKS`, 4, power of two, at most `NUM_REGS`, and `NUM_REGS` is a multiple of it.
- Derived widths: `WARP_W` = $clog2(`NUM_WARPS`); `REG_W` = $clog2(`NUM_REGS`); `LANES_W` = `THREADS_PER_WARP`*`DATA_WIDTH`.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_req_valid`  in  1  operand read request.
- `rd_req_ready`  out  1  request accepted when valid&&ready.
- `rd_warp_id`  in  `WARP_W`  warp of the read.
- `rs1_addr`, `rs2_addr`  in  `REG_W` each  source registers.
- `rd_rsp_valid`  out  1  one-cycle pulse; response data is valid.
- `rs1_data`, `rs2_data`  out  `LANES_W` each  lane i at bits [i*`DATA_WIDTH` +: `DATA_WIDTH`].
- `wr_en`  in  1  writeback strobe; always accepted.
- `wr_warp_id`  in  `WARP_W`  warp of the write.
- `wr_addr`  in  `REG_W`  destination register.
- `wr_mask`  in  `THREADS_PER_WARP`  per-lane write enable.
- `wr_data`  in  `LANES_W`  write data.
- `conflict_count`  out  16  saturating count of serialised requests.

## Operation
- Bank mapping:
  - bank = (warp + reg) mod `NUM_BANKS`.
  - Entry within the bank = warp*(`NUM_REGS`/`NUM_BANKS`) + reg/`NUM_BANKS`.
  - The warp swizzle spreads the same register of different warps across banks.
- Register 0 is hardwired:
  - Reads of register 0 return all zeros.
  - Writes to register 0 are dropped.
- Conflict definition:
  - A conflict exists when rs1 and rs2 map to the same bank with rs1≠rs2.
  - rs1==rs2 is not a conflict; both outputs come from one read.
- FSM states: `IDLE` and `SECOND`.
  - In `IDLE`, an accepted request without a conflict reads both operands in the accept cycle and stays in `IDLE`.
  - In `IDLE`, an accepted request with a conflict reads rs1 in the accept cycle. rs1's result is held internally and the FSM goes to `SECOND`.
  - In `SECOND`, rs2 is read, then the FSM returns to `IDLE`. `conflict_count` increments at that point, saturating at 16'hFFFF.
- Writes:
  - One write per cycle; lanes with `wr_mask`=0 keep their old value.
  - A write never stalls and is never blocked by reads (separate bank write port).
- Bypass:
  - A write and a read of the same (warp, reg) in the same cycle returns the new value for masked lanes and the old value for unmasked lanes.
  - This applies to both operands in `IDLE`, and to rs2 in `SECOND`.
  - rs1 of a conflicting request reflects state as of its accept cycle.
- Storage is not reset; contents are undefined until written.

## Timing
- Reset values:
  - `rd_req_ready`=0 while `rst_n`=0, then 1 (`IDLE`).
  - `rd_rsp_valid`=0; `rs1_data`=`rs2_data`=0; `conflict_count`=0; FSM=`IDLE`.
- `rd_req_ready` = (state==`IDLE`) && `rst_n`, decoded from state only, with no combinational path from the request inputs.
- Latency:
  - No-conflict response: `rd_rsp_valid` in cycle N+1 for accept at cycle N.
  - Conflict response: `rd_rsp_valid` in cycle N+2, with `rd_req_ready`=0 in cycle N+1.
- Throughput: one request per cycle without conflicts; two cycles per conflicting request.
- The response has no backpressure. Data is valid only in the `rd_rsp_valid` cycle and holds the last value otherwise.
- Reset asserted in `SECOND`:
  - The pending request is dropped and no response is issued.
  - Writes already committed remain.

## Structure
- Package `regfile_pkg` holds:
  - the `rf_state_e` {`IDLE`, `SECOND`} enum;
  - the width localparams;
  - functions `bank_of(warp, reg)` and `entry_of(warp, reg)`.
- Sub-module `regfile_bank`:
  - one instance per bank, generated;
  - 1R1W, synchronous read, per-lane write enable;
  - depth `NUM_WARPS`*`NUM_REGS`/`NUM_BANKS`.
- The top level holds the conflict detection, FSM, rs1 holding register, bypass muxes and counter.

## Test plan
- Defaults; write warp 3 reg 5 lanes = lane index with mask all-ones; read rs1=5, rs2=6 (different banks) -> `rd_rsp_valid` at N+1, `rs1_data` lane i = i.
- Warp 0: rs1=1, rs2=5 (both bank 1) -> `rd_req_ready`=0 at N+1, response at N+2, `conflict_count`=1. Back-to-back non-conflicting requests give one response per cycle.
- Write reg 0 with 32'hDEADBEEF; read rs1=rs2=0 -> all zeros, no conflict counted.
- Same-cycle write of warp 2 reg 7 = 32'hA5A5A5A5 with mask 32'h0000FFFF, and a read of reg 7 -> lanes 0-15 read A5A5A5A5, lanes 16-31 read the old value.
- Force 65540 conflicting requests -> `conflict_count` holds at 16'hFFFF.
- Assert `rst_n` low during `SECOND` -> no `rd_rsp_valid`; after release `rd_req_ready`=1 and a new read returns the previously written data.
